// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types for the multicycle control FSM:
// state codes, opcode constants, mux select codes.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_R     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_JMP = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b111001;
  localparam logic [5:0] OP_SW  = 6'b111100;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_BEQ,
    CL_BNE,
    CL_JMP,
    CL_LW,
    CL_SW,
    CL_ILL
  } op_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e c;
    c = CL_ILL;
    if (op[5:4] == 2'b00) begin
      c = CL_R;
    end else if (op[5:4] == 2'b01) begin
      c = CL_I;
    end else begin
      case (op)
        OP_BEQ:  c = CL_BEQ;
        OP_BNE:  c = CL_BNE;
        OP_JMP:  c = CL_JMP;
        OP_LW:   c = CL_LW;
        OP_SW:   c = CL_SW;
        default: c = CL_ILL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/mcfsm_out_decode.sv
// Moore output decode: state register to
// datapath control bundle, purely combinational.
module mcfsm_out_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_ONE;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_src    = PCSRC_SEQ;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNC;
      end
      S_WB_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNC;
      end
      S_WB_I: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCSRC_BR;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control: next-state logic, branch sense,
// illegal-opcode pulse and retired-instruction counter.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             BEQ,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  op_class_e        cls;
  logic             beq_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  ctrl_t            dec;
  ctrl_t            ctrl;

  assign cls = op_class(opcode);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (cls)
          CL_R:           state_d = S_EXEC_R;
          CL_I:           state_d = S_EXEC_I;
          CL_LW, CL_SW:   state_d = S_MEM_ADDR;
          CL_BEQ, CL_BNE: state_d = S_BRANCH;
          CL_JMP:         state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_R:     state_d = S_FETCH;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (cls == CL_LW) begin
          state_d = S_MEM_RD;
        end else if (cls == CL_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Only completed instructions retire; the illegal path
  // leaves DECODE straight for FETCH and is not counted.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      unique case (state_q)
        S_WB_R, S_WB_I, S_WB_MEM,
        S_MEM_WR, S_BRANCH, S_JUMP: retire = 1'b1;
        default:                    retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      beq_q     <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == S_DECODE) && (cls == CL_ILL);
      if ((state_q == S_DECODE) && (cls != CL_ILL)) begin
        beq_q <= ~opcode[0];
      end
      if (retire) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  mcfsm_out_decode u_dec (
    .state_i (state_q),
    .ctrl_o  (dec)
  );

  // Reset masks the FETCH decode so nothing fires while held.
  assign ctrl = rst ? dec : '0;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign PCSrc       = ctrl.pc_src;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign BEQ         = beq_q;
  assign illegal_op  = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm:
// walks each instruction class, waits, illegal, reset, wrap.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, BEQ, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSrc, ALUOp, ALUSrcB;
  logic       illegal_op;
  logic [3:0] instr_count;

  int vec;
  int miss;
  logic [3:0] exp_cnt;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,
  //  IRWrite,ALUSrcA,RegWrite,RegDst,PCSrc,ALUOp,ALUSrcB}
  logic [15:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst,
                PCSrc, ALUOp, ALUSrcB};

  localparam logic [15:0] C_ZERO  = 16'b0000000000_00_00_00;
  localparam logic [15:0] C_FETCH = 16'b1001001000_00_00_01;
  localparam logic [15:0] C_DEC   = 16'b0000000000_00_00_10;
  localparam logic [15:0] C_EXR   = 16'b0000000100_00_10_00;
  localparam logic [15:0] C_WBR   = 16'b0000000011_00_00_00;
  localparam logic [15:0] C_EXI   = 16'b0000000100_00_10_10;
  localparam logic [15:0] C_WBI   = 16'b0000000010_00_00_00;
  localparam logic [15:0] C_MADR  = 16'b0000000100_00_00_10;
  localparam logic [15:0] C_MRD   = 16'b0011000000_00_00_00;
  localparam logic [15:0] C_WBM   = 16'b0000010010_00_00_00;
  localparam logic [15:0] C_MWR   = 16'b0010100000_00_00_00;
  localparam logic [15:0] C_BR    = 16'b0100000100_01_01_00;
  localparam logic [15:0] C_JMP   = 16'b1000000000_10_00_00;

  multicycle_control_fsm #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .BEQ         (BEQ),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .PCSrc       (PCSrc),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    opcode = 6'b000000;
    mem_ready = 1'b1;
    #3;
    vec++;
    if (dut.state_q !== 4'd0 || ctl !== C_ZERO) begin
      miss++;
      $display("FAIL reset_hold state=%0d ctl=%h want 0/%h",
               dut.state_q, ctl, C_ZERO);
    end
    vec++;
    if (instr_count !== 4'd0 || BEQ !== 1'b0 || illegal_op !== 1'b0) begin
      miss++;
      $display("FAIL reset_regs cnt=%0d beq=%b ill=%b want 0/0/0",
               instr_count, BEQ, illegal_op);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec++;
    if (dut.state_q !== 4'd0 || ctl !== C_FETCH) begin
      miss++;
      $display("FAIL reset_release state=%0d ctl=%h want 0/%h",
               dut.state_q, ctl, C_FETCH);
    end
  endtask

  task automatic test_rtype;
    logic [3:0]  es [4];
    logic [15:0] ec [4];
    es[0] = 4'd1; ec[0] = C_DEC;
    es[1] = 4'd2; ec[1] = C_EXR;
    es[2] = 4'd4; ec[2] = C_WBR;
    es[3] = 4'd0; ec[3] = C_FETCH;
    opcode = 6'b000010;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vec++;
      if (dut.state_q !== es[i] || ctl !== ec[i]) begin
        miss++;
        $display("FAIL rtype[%0d] state=%0d ctl=%h want %0d/%h",
                 i, dut.state_q, ctl, es[i], ec[i]);
      end
    end
    exp_cnt = exp_cnt + 4'd1;
    vec++;
    if (instr_count !== exp_cnt) begin
      miss++;
      $display("FAIL rtype_cnt got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_itype;
    logic [3:0]  es [4];
    logic [15:0] ec [4];
    es[0] = 4'd1; ec[0] = C_DEC;
    es[1] = 4'd3; ec[1] = C_EXI;
    es[2] = 4'd5; ec[2] = C_WBI;
    es[3] = 4'd0; ec[3] = C_FETCH;
    opcode = 6'b010101;
    for (int i = 0; i < 4; i++) begin
      step();
      vec++;
      if (dut.state_q !== es[i] || ctl !== ec[i]) begin
        miss++;
        $display("FAIL itype[%0d] state=%0d ctl=%h want %0d/%h",
                 i, dut.state_q, ctl, es[i], ec[i]);
      end
    end
    exp_cnt = exp_cnt + 4'd1;
    vec++;
    if (instr_count !== exp_cnt) begin
      miss++;
      $display("FAIL itype_cnt got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_lw_wait;
    opcode = 6'b111001;
    mem_ready = 1'b0;
    step();
    step();
    vec++;
    if (dut.state_q !== 4'd6 || ctl !== C_MADR) begin
      miss++;
      $display("FAIL lw_addr state=%0d ctl=%h want 6/%h",
               dut.state_q, ctl, C_MADR);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (dut.state_q !== 4'd7 || ctl !== C_MRD) begin
        miss++;
        $display("FAIL lw_wait[%0d] state=%0d ctl=%h want 7/%h",
                 i, dut.state_q, ctl, C_MRD);
      end
      mem_ready = (i == 3);
      step();
    end
    vec++;
    if (dut.state_q !== 4'd8 || ctl !== C_WBM) begin
      miss++;
      $display("FAIL lw_wb state=%0d ctl=%h want 8/%h",
               dut.state_q, ctl, C_WBM);
    end
    step();
    exp_cnt = exp_cnt + 4'd1;
    vec++;
    if (dut.state_q !== 4'd0 || instr_count !== exp_cnt) begin
      miss++;
      $display("FAIL lw_done state=%0d cnt=%0d want 0/%0d",
               dut.state_q, instr_count, exp_cnt);
    end
  endtask

  task automatic test_branch;
    logic [5:0] ops [2];
    logic       eb  [2];
    ops[0] = 6'b100001; eb[0] = 1'b0;
    ops[1] = 6'b100000; eb[1] = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      opcode = ops[i];
      step();
      step();
      vec++;
      if (dut.state_q !== 4'd10 || ctl !== C_BR || BEQ !== eb[i]) begin
        miss++;
        $display("FAIL branch[%0d] state=%0d ctl=%h beq=%b want 10/%h/%b",
                 i, dut.state_q, ctl, BEQ, C_BR, eb[i]);
      end
      step();
      exp_cnt = exp_cnt + 4'd1;
      vec++;
      if (dut.state_q !== 4'd0 || instr_count !== exp_cnt) begin
        miss++;
        $display("FAIL branch_done[%0d] state=%0d cnt=%0d want 0/%0d",
                 i, dut.state_q, instr_count, exp_cnt);
      end
    end
  endtask

  task automatic test_jmp;
    opcode = 6'b100010;
    step();
    step();
    vec++;
    if (dut.state_q !== 4'd11 || ctl !== C_JMP) begin
      miss++;
      $display("FAIL jmp state=%0d ctl=%h want 11/%h",
               dut.state_q, ctl, C_JMP);
    end
    step();
    exp_cnt = exp_cnt + 4'd1;
    vec++;
    if (dut.state_q !== 4'd0 || instr_count !== exp_cnt) begin
      miss++;
      $display("FAIL jmp_done state=%0d cnt=%0d want 0/%0d",
               dut.state_q, instr_count, exp_cnt);
    end
  endtask

  task automatic test_sw;
    opcode = 6'b111100;
    mem_ready = 1'b1;
    step();
    step();
    step();
    vec++;
    if (dut.state_q !== 4'd9 || ctl !== C_MWR) begin
      miss++;
      $display("FAIL sw state=%0d ctl=%h want 9/%h",
               dut.state_q, ctl, C_MWR);
    end
    step();
    exp_cnt = exp_cnt + 4'd1;
    vec++;
    if (dut.state_q !== 4'd0 || instr_count !== exp_cnt) begin
      miss++;
      $display("FAIL sw_done state=%0d cnt=%0d want 0/%0d",
               dut.state_q, instr_count, exp_cnt);
    end
  endtask

  task automatic test_illegal;
    opcode = 6'b110000;
    step();
    vec++;
    if (dut.state_q !== 4'd1 || ctl !== C_DEC || illegal_op !== 1'b0) begin
      miss++;
      $display("FAIL ill_dec state=%0d ctl=%h ill=%b want 1/%h/0",
               dut.state_q, ctl, illegal_op, C_DEC);
    end
    step();
    vec++;
    if (dut.state_q !== 4'd0 || ctl !== C_FETCH || illegal_op !== 1'b1 ||
        instr_count !== exp_cnt) begin
      miss++;
      $display("FAIL ill_pulse state=%0d ctl=%h ill=%b cnt=%0d want 0/%h/1/%0d",
               dut.state_q, ctl, illegal_op, instr_count, C_FETCH, exp_cnt);
    end
    opcode = 6'b100010;
    step();
    vec++;
    if (dut.state_q !== 4'd1 || illegal_op !== 1'b0) begin
      miss++;
      $display("FAIL ill_clear state=%0d ill=%b want 1/0",
               dut.state_q, illegal_op);
    end
    step();
    step();
    exp_cnt = exp_cnt + 4'd1;
    vec++;
    if (dut.state_q !== 4'd0 || instr_count !== exp_cnt) begin
      miss++;
      $display("FAIL ill_next state=%0d cnt=%0d want 0/%0d",
               dut.state_q, instr_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_sw;
    opcode = 6'b111100;
    mem_ready = 1'b0;
    step();
    step();
    step();
    step();
    vec++;
    if (dut.state_q !== 4'd9 || MemWrite !== 1'b1) begin
      miss++;
      $display("FAIL sw_wait state=%0d memwrite=%b want 9/1",
               dut.state_q, MemWrite);
    end
    #2;
    rst = 1'b0;
    #1;
    exp_cnt = 4'd0;
    vec++;
    if (dut.state_q !== 4'd0 || ctl !== C_ZERO || instr_count !== 4'd0 ||
        BEQ !== 1'b0) begin
      miss++;
      $display("FAIL sw_abort state=%0d ctl=%h cnt=%0d beq=%b want 0/%h/0/0",
               dut.state_q, ctl, instr_count, BEQ, C_ZERO);
    end
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    vec++;
    if (dut.state_q !== 4'd0 || ctl !== C_FETCH) begin
      miss++;
      $display("FAIL sw_restart state=%0d ctl=%h want 0/%h",
               dut.state_q, ctl, C_FETCH);
    end
  endtask

  task automatic test_wrap;
    opcode = 6'b100010;
    for (int n = 0; n < 16; n++) begin
      step();
      step();
      step();
      exp_cnt = exp_cnt + 4'd1;
      vec++;
      if (dut.state_q !== 4'd0 || instr_count !== exp_cnt) begin
        miss++;
        $display("FAIL wrap[%0d] state=%0d cnt=%0d want 0/%0d",
                 n, dut.state_q, instr_count, exp_cnt);
      end
    end
    vec++;
    if (instr_count !== 4'd0) begin
      miss++;
      $display("FAIL wrap_zero cnt=%0d want 0", instr_count);
    end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    exp_cnt = 4'd0;
    test_reset();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_branch();
    test_jmp();
    test_sw();
    test_illegal();
    test_reset_mid_sw();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
